// File: rtl/vlsu_cam_pkg.sv
// Shared CAM allocator defaults and types, also used by vlsu_cam_top.
package vlsu_cam_pkg;

   localparam int unsigned CAM_WIDTH   = 50;
   localparam int unsigned CAM_DEPTH   = 32;
   localparam int unsigned CAM_READ    = 3;
   localparam int unsigned CAM_ADDRESS = $clog2(CAM_DEPTH);

   typedef logic [CAM_WIDTH-1:0]   width_t;
   typedef logic [CAM_ADDRESS-1:0] addr_t;
   typedef logic [CAM_DEPTH-1:0]   depth_t;
   typedef logic [CAM_ADDRESS:0]   count_t;

endpackage

// File: rtl/vlsu_cam_alloc.sv
// Circular-buffer allocator feeding a CAM: write strobe, head index and per-port enables.
// Optional macro VLSU_CAM_ALLOC_BYPASS_EN: accept while full when the head retires that cycle.
module vlsu_cam_alloc
   import vlsu_cam_pkg::*;
#(
   parameter  int unsigned WIDTH   = CAM_WIDTH,
   parameter  int unsigned DEPTH   = CAM_DEPTH,
   parameter  int unsigned READ    = CAM_READ,
   localparam int unsigned ADDRESS = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic                          alloc_valid_i,
   input  logic [WIDTH-1:0]              alloc_data_i,
   output logic                          alloc_ready_o,
   input  logic                          retire_i,
   input  logic                          flush_i,
   output logic                          write_o,
   output logic [ADDRESS-1:0]            write_addr_o,
   output logic [WIDTH-1:0]              write_data_o,
   output logic [ADDRESS-1:0]            head_o,
   output logic [READ-1:0][DEPTH-1:0]    enable_o,
   output logic [ADDRESS:0]              count_o,
   output logic                          full_o,
   output logic                          empty_o
);

   localparam logic [ADDRESS-1:0] PtrOne    = ADDRESS'(1);
   localparam logic [ADDRESS:0]   CountOne  = (ADDRESS+1)'(1);
   localparam logic [ADDRESS:0]   CountFull = (ADDRESS+1)'(DEPTH);

   logic [ADDRESS-1:0] head_q, head_d;
   logic [ADDRESS-1:0] tail_q, tail_d;
   logic [ADDRESS:0]   count_q, count_d;
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic               write_q, write_d;
   logic [ADDRESS-1:0] waddr_q, waddr_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;

   logic accept;
   logic retire_ok;

   assign full_o    = (count_q == CountFull);
   assign empty_o   = (count_q == '0);
   assign retire_ok = retire_i && valid_q[head_q];

`ifdef VLSU_CAM_ALLOC_BYPASS_EN
   assign alloc_ready_o = (!full_o || retire_ok) && !flush_i;
`else
   assign alloc_ready_o = !full_o && !flush_i;
`endif

   assign accept = alloc_valid_i && alloc_ready_o;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      write_d = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;

      // Pending write becomes visible on the same edge the CAM stores it; retire clears afterwards.
      if (write_q)   valid_d[waddr_q] = 1'b1;
      if (retire_ok) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PtrOne;
      end

      if (accept) begin
         write_d = 1'b1;
         waddr_d = tail_q;
         wdata_d = alloc_data_i;
         tail_d  = tail_q + PtrOne;
      end

      case ({accept, retire_ok})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase

      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         valid_d = '0;
         write_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         write_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         write_q <= write_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign write_o      = write_q;
   assign write_addr_o = waddr_q;
   assign write_data_o = wdata_q;
   assign head_o       = head_q;
   assign count_o      = count_q;
   assign enable_o     = {READ{valid_q}};

endmodule

// File: tb/tb_vlsu_cam_alloc.sv
// Scoreboard bench for vlsu_cam_alloc; honours VLSU_CAM_ALLOC_BYPASS_EN when defined.
module tb_vlsu_cam_alloc;
   import vlsu_cam_pkg::*;

   localparam int unsigned WIDTH   = CAM_WIDTH;
   localparam int unsigned DEPTH   = CAM_DEPTH;
   localparam int unsigned READ    = CAM_READ;
   localparam int unsigned ADDRESS = CAM_ADDRESS;

   logic                       clk = 1'b0;
   logic                       arst_n = 1'b0;
   logic                       alloc_valid_i = 1'b0;
   logic [WIDTH-1:0]           alloc_data_i = '0;
   logic                       alloc_ready_o;
   logic                       retire_i = 1'b0;
   logic                       flush_i = 1'b0;
   logic                       write_o;
   logic [ADDRESS-1:0]         write_addr_o;
   logic [WIDTH-1:0]           write_data_o;
   logic [ADDRESS-1:0]         head_o;
   logic [READ-1:0][DEPTH-1:0] enable_o;
   logic [ADDRESS:0]           count_o;
   logic                       full_o;
   logic                       empty_o;

   vlsu_cam_alloc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READ(READ)) dut (
      .clk(clk), .arst_n(arst_n),
      .alloc_valid_i(alloc_valid_i), .alloc_data_i(alloc_data_i), .alloc_ready_o(alloc_ready_o),
      .retire_i(retire_i), .flush_i(flush_i),
      .write_o(write_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
      .head_o(head_o), .enable_o(enable_o), .count_o(count_o),
      .full_o(full_o), .empty_o(empty_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int               due;
      logic [ADDRESS-1:0] addr;
      logic [WIDTH-1:0] data;
   } wr_t;
   wr_t sbq[$];

   // Reference model: slot occupancy and pointers as plain integers.
   int mh, mt, mc;
   bit mv[DEPTH];
   bit mp;
   int mpa;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mh = 0; mt = 0; mc = 0; mp = 0; mpa = 0;
      for (int i = 0; i < DEPTH; i++) mv[i] = 0;
   endtask

   function automatic logic [DEPTH-1:0] model_map();
      logic [DEPTH-1:0] m;
      for (int i = 0; i < DEPTH; i++) m[i] = mv[i];
      return m;
   endfunction

   task automatic check_state();
      logic [READ-1:0][DEPTH-1:0] en;
      for (int r = 0; r < READ; r++) en[r] = model_map();
      chk("count_o", 128'(count_o), 128'(mc));
      chk("head_o",  128'(head_o),  128'(mh));
      chk("full_o",  128'(full_o),  128'(mc == DEPTH));
      chk("empty_o", 128'(empty_o), 128'(mc == 0));
      chk("enable_o", 128'(enable_o), 128'(en));
   endtask

   // Called at posedge+1: drive one cycle, check ready, advance model, check registered state.
   task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit f);
      bit rdy, ret, acc;
      alloc_valid_i = v; alloc_data_i = d; retire_i = r; flush_i = f;
      #1;
      ret = r && mv[mh];
`ifdef VLSU_CAM_ALLOC_BYPASS_EN
      rdy = (mc < DEPTH || ret) && !f;
`else
      rdy = (mc < DEPTH) && !f;
`endif
      chk("alloc_ready_o", 128'(alloc_ready_o), 128'(rdy));
      acc = v && rdy;
      if (f) begin
         model_reset();
      end else begin
         if (mp) mv[mpa] = 1;
         mp = 0;
         if (ret) begin
            mv[mh] = 0;
            mh = (mh + 1) % DEPTH;
            mc--;
         end
         if (acc) begin
            sbq.push_back('{due: cyc + 1, addr: ADDRESS'(mt), data: d});
            mp = 1; mpa = mt;
            mt = (mt + 1) % DEPTH;
            mc++;
         end
      end
      @(posedge clk); #1;
      check_state();
   endtask

   function automatic logic [WIDTH-1:0] rnd_data();
      return WIDTH'({$urandom(), $urandom()});
   endfunction

   always @(negedge clk) begin
      if (arst_n) begin
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            chk("write_o", 128'(write_o), 128'(1));
            chk("write_addr_o", 128'(write_addr_o), 128'(sbq[0].addr));
            chk("write_data_o", 128'(write_data_o), 128'(sbq[0].data));
            void'(sbq.pop_front());
         end else begin
            chk("write_o idle", 128'(write_o), 128'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #23 arst_n = 1'b1;
      @(posedge clk); #1;
      check_state();
      chk("reset ready", 128'(alloc_ready_o), 128'(1));
      chk("reset write_o", 128'(write_o), 128'(0));

      // Fill all entries with data j+1, addresses 0..DEPTH-1.
      for (int j = 0; j < DEPTH; j++) step(1, WIDTH'(j + 1), 0, 0);
      chk("full after fill", 128'(full_o), 128'(1));
      step(0, '0, 0, 0);
      chk("enable all ones", 128'(enable_o[0]), 128'({DEPTH{1'b1}}));

      // Retire five, then wrap-around allocation at address 0.
      for (int j = 0; j < 5; j++) step(0, '0, 1, 0);
      chk("head after retire", 128'(head_o), 128'(5));
      chk("count after retire", 128'(count_o), 128'(DEPTH - 5));
      step(1, WIDTH'(50'h2_ABCD_1234_5678), 0, 0);
      step(0, '0, 0, 0);

      // Retire on empty, and retire while head write still pending.
      step(0, '0, 0, 1);
      step(0, '0, 1, 0);
      step(1, rnd_data(), 0, 0);
      step(0, '0, 1, 0);
      chk("pending head kept", 128'(count_o), 128'(1));
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);

      // Full with simultaneous accept and retire.
      step(0, '0, 0, 1);
      for (int j = 0; j < DEPTH; j++) step(1, rnd_data(), 0, 0);
      step(0, '0, 0, 0);
      step(1, rnd_data(), 1, 0);
`ifdef VLSU_CAM_ALLOC_BYPASS_EN
      chk("bypass count", 128'(count_o), 128'(DEPTH));
`else
      chk("no bypass count", 128'(count_o), 128'(DEPTH - 1));
`endif
      step(0, '0, 0, 0);

      // Flush at count 10 with accept and retire active.
      step(0, '0, 0, 1);
      for (int j = 0; j < 10; j++) step(1, rnd_data(), 0, 0);
      step(0, '0, 0, 0);
      step(1, rnd_data(), 1, 1);
      chk("flush count", 128'(count_o), 128'(0));
      chk("flush enable", 128'(enable_o), 128'(0));

      // Randomised traffic.
      for (int n = 0; n < 600; n++)
         step($urandom_range(0, 99) < 70, rnd_data(), $urandom_range(0, 99) < 40,
              $urandom_range(0, 99) < 3);

      // Reset asserted during a write_o cycle.
      step(0, '0, 0, 1);
      step(1, rnd_data(), 0, 0);
      alloc_valid_i = 0; retire_i = 0; flush_i = 0;
      sbq.delete();
      model_reset();
      arst_n = 1'b0;
      #1;
      chk("rst write_o", 128'(write_o), 128'(0));
      chk("rst write_addr_o", 128'(write_addr_o), 128'(0));
      chk("rst write_data_o", 128'(write_data_o), 128'(0));
      check_state();
      @(posedge clk); #3 arst_n = 1'b1;
      @(posedge clk); #1;
      check_state();
      step(0, '0, 0, 0);
      step(0, '0, 1, 0);
      chk("post-reset ready", 128'(alloc_ready_o), 128'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
